// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three 2-entry write-back queues (ALU, LSU, BRU) with branch squash/free, one registered ROB write port.
// Define CDB_FIXED_PRIORITY_EN for fixed ALU > LSU > BRU priority; the default build arbitrates round-robin.
module cdb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        enReq0,
    input  logic        enReq1,
    input  logic        enReq2,
    input  logic [3:0]  ReqTag0,
    input  logic [3:0]  ReqTag1,
    input  logic [3:0]  ReqTag2,
    input  logic [31:0] ReqData0,
    input  logic [31:0] ReqData1,
    input  logic [31:0] ReqData2,
    input  logic [3:0]  ReqBranchTag0,
    input  logic [3:0]  ReqBranchTag1,
    input  logic [3:0]  ReqBranchTag2,
    output logic        full0,
    output logic        full1,
    output logic        full2,
    input  logic        bFreeEn,
    input  logic [1:0]  bFreeNum,
    input  logic        misTaken,
    output logic        enWrtO,
    output logic [3:0]  WrtTagO,
    output logic [31:0] WrtDataO
);

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [3:0]  bt;
    } entry_t;

    entry_t     q       [3][2];
    logic [1:0] cnt     [3];
    entry_t     q_nxt   [3][2];
    logic [1:0] cnt_nxt [3];

    logic       req_v   [3];
    entry_t     req_e   [3];

    entry_t     c_e     [3][2];
    logic [1:0] c_cnt   [3];
    logic [2:0] head_ok;

    logic       gnt_any;
    logic [1:0] gnt_idx;
    entry_t     win;

`ifndef CDB_FIXED_PRIORITY_EN
    logic [1:0] last_grant;
`endif

    // Handshake: enReqN is accepted on a rising edge where rdy=1 and fullN=0;
    // fullN is the inverse of ready and comes straight from the registered count.
    always_comb begin
        req_v[0] = enReq0;
        req_v[1] = enReq1;
        req_v[2] = enReq2;
        req_e[0] = {ReqTag0, ReqData0, ReqBranchTag0};
        req_e[1] = {ReqTag1, ReqData1, ReqBranchTag1};
        req_e[2] = {ReqTag2, ReqData2, ReqBranchTag2};
    end

    assign full0 = (cnt[0] == 2'd2);
    assign full1 = (cnt[1] == 2'd2);
    assign full2 = (cnt[2] == 2'd2);

    // Squash view of each queue: killed entries vanish and survivors slide to the head,
    // so a killed head lets the entry behind it compete in the same cycle.
    always_comb begin
        logic k0, k1, s0, s1;
        for (int i = 0; i < 3; i++) begin
            k0 = misTaken & q[i][0].bt[bFreeNum];
            k1 = misTaken & q[i][1].bt[bFreeNum];
            s0 = (cnt[i] != 2'd0) & ~k0;
            s1 = (cnt[i] == 2'd2) & ~k1;
            c_e[i][0] = q[i][0];
            c_e[i][1] = q[i][1];
            c_cnt[i]  = 2'd0;
            if (s0) begin
                c_cnt[i] = s1 ? 2'd2 : 2'd1;
            end else if (s1) begin
                c_e[i][0] = q[i][1];
                c_cnt[i]  = 2'd1;
            end
            head_ok[i] = s0 | s1;
        end
    end

    always_comb begin
        gnt_any = |head_ok;
        gnt_idx = 2'd0;
`ifdef CDB_FIXED_PRIORITY_EN
        if (head_ok[0])      gnt_idx = 2'd0;
        else if (head_ok[1]) gnt_idx = 2'd1;
        else if (head_ok[2]) gnt_idx = 2'd2;
`else
        // Search starts one past the last winner.
        case (last_grant)
            2'd0: begin
                if (head_ok[1])      gnt_idx = 2'd1;
                else if (head_ok[2]) gnt_idx = 2'd2;
                else if (head_ok[0]) gnt_idx = 2'd0;
            end
            2'd1: begin
                if (head_ok[2])      gnt_idx = 2'd2;
                else if (head_ok[0]) gnt_idx = 2'd0;
                else if (head_ok[1]) gnt_idx = 2'd1;
            end
            default: begin
                if (head_ok[0])      gnt_idx = 2'd0;
                else if (head_ok[1]) gnt_idx = 2'd1;
                else if (head_ok[2]) gnt_idx = 2'd2;
            end
        endcase
`endif
        case (gnt_idx)
            2'd1:    win = c_e[1][0];
            2'd2:    win = c_e[2][0];
            default: win = c_e[0][0];
        endcase
    end

    always_comb begin
        logic       pop, take;
        logic [1:0] rem;
        for (int i = 0; i < 3; i++) begin
            pop  = gnt_any && (gnt_idx == 2'(i));
            take = req_v[i] && (cnt[i] != 2'd2) && !(misTaken && req_e[i].bt[bFreeNum]);
            rem  = c_cnt[i] - {1'b0, pop};
            q_nxt[i][0] = pop ? c_e[i][1] : c_e[i][0];
            q_nxt[i][1] = c_e[i][1];
            if (take) begin
                if (rem == 2'd0) q_nxt[i][0] = req_e[i];
                else             q_nxt[i][1] = req_e[i];
            end
            cnt_nxt[i] = rem + {1'b0, take};
            // A resolved-correct branch frees its mask bit everywhere, including the new arrival.
            if (bFreeEn && !misTaken) begin
                q_nxt[i][0].bt[bFreeNum] = 1'b0;
                q_nxt[i][1].bt[bFreeNum] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i]  <= 2'd0;
                q[i][0] <= '0;
                q[i][1] <= '0;
            end
            enWrtO     <= 1'b0;
            WrtTagO    <= 4'b1000;
            WrtDataO   <= 32'd0;
`ifndef CDB_FIXED_PRIORITY_EN
            last_grant <= 2'd2;
`endif
        end else if (rdy) begin
            for (int i = 0; i < 3; i++) begin
                cnt[i]  <= cnt_nxt[i];
                q[i][0] <= q_nxt[i][0];
                q[i][1] <= q_nxt[i][1];
            end
            enWrtO <= gnt_any;
            if (gnt_any) begin
                WrtTagO    <= win.tag;
                WrtDataO   <= win.data;
`ifndef CDB_FIXED_PRIORITY_EN
                last_grant <= gnt_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected ROB writes are queued as stimulus is issued and a
// negedge monitor pops and compares every fresh write; status outputs are checked inline.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        enReq0, enReq1, enReq2;
  logic [3:0]  ReqTag0, ReqTag1, ReqTag2;
  logic [31:0] ReqData0, ReqData1, ReqData2;
  logic [3:0]  ReqBranchTag0, ReqBranchTag1, ReqBranchTag2;
  logic        full0, full1, full2;
  logic        bFreeEn, misTaken;
  logic [1:0]  bFreeNum;
  logic        enWrtO;
  logic [3:0]  WrtTagO;
  logic [31:0] WrtDataO;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] exp_q[$];
  logic [35:0] mon_exp;
  logic        edge_live = 1'b0;
  int          ord29[10];
  int          ord33[6];

  cdb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enReq0(enReq0), .enReq1(enReq1), .enReq2(enReq2),
    .ReqTag0(ReqTag0), .ReqTag1(ReqTag1), .ReqTag2(ReqTag2),
    .ReqData0(ReqData0), .ReqData1(ReqData1), .ReqData2(ReqData2),
    .ReqBranchTag0(ReqBranchTag0), .ReqBranchTag1(ReqBranchTag1), .ReqBranchTag2(ReqBranchTag2),
    .full0(full0), .full1(full1), .full2(full2),
    .bFreeEn(bFreeEn), .bFreeNum(bFreeNum), .misTaken(misTaken),
    .enWrtO(enWrtO), .WrtTagO(WrtTagO), .WrtDataO(WrtDataO)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // A write is fresh only when the edge that produced it was a live (rdy, no reset) edge.
  always @(posedge clk) edge_live <= rdy && !rst;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (enWrtO === 1'b1 && edge_live) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: got tag=%0h data=%h, required no write", WrtTagO, WrtDataO);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({WrtTagO, WrtDataO} !== mon_exp) begin
          n_fail++;
          $display("FAIL write_order: got tag=%0h data=%h, required tag=%0h data=%h",
                   WrtTagO, WrtDataO, mon_exp[35:32], mon_exp[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] tag,
                         input logic [31:0] data, input logic [3:0] bt);
    case (n)
      0: begin enReq0 = v; ReqTag0 = tag; ReqData0 = data; ReqBranchTag0 = bt; end
      1: begin enReq1 = v; ReqTag1 = tag; ReqData1 = data; ReqBranchTag1 = bt; end
      default: begin enReq2 = v; ReqTag2 = tag; ReqData2 = data; ReqBranchTag2 = bt; end
    endcase
  endtask

  task automatic idle();
    rdy = 1'b1;
    bFreeEn = 1'b0;
    bFreeNum = 2'd0;
    misTaken = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [3:0] tag, input logic [31:0] data);
    exp_q.push_back({tag, data});
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) tick();
  endtask

  function automatic logic [31:0] dat29(input int tag);
    case (tag)
      1:       return 32'hA000_0001;
      2:       return 32'hB000_0002;
      default: return 32'hC000_0004;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
`ifdef CDB_FIXED_PRIORITY_EN
    ord29 = '{1, 1, 1, 1, 1, 1, 2, 2, 4, 4};
    ord33 = '{0, 3, 1, 4, 2, 5};
`else
    ord29 = '{1, 2, 4, 1, 2, 4, 1, 2, 4, 1};
    ord33 = '{0, 1, 2, 3, 4, 5};
`endif
    idle();
    rst = 1'b1;

    // Reset state
    do_reset();
    check("rst_enWrtO", enWrtO, 0);
    check("rst_WrtTagO", WrtTagO, 4'b1000);
    check("rst_WrtDataO", WrtDataO, 0);
    check("rst_full", {full0, full1, full2}, 3'b000);

    // Single request latency: enqueue at edge N, write after edge N+1, then idle
    push(4'd3, 32'hDEAD_BEEF);
    set_req(0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'd0);
    tick();
    idle();
    check("lat_edgeN_en", enWrtO, 0);
    tick();
    check("lat_write_en", enWrtO, 1);
    check("lat_write_tag", WrtTagO, 4'd3);
    check("lat_write_data", WrtDataO, 32'hDEAD_BEEF);
    tick();
    check("lat_after_en", enWrtO, 0);
    check("lat_hold_tag", WrtTagO, 4'd3);
    drain("lat_drain");

    // All three requesters held valid for six edges
    do_reset();
    for (int i = 0; i < 10; i++) push(4'(ord29[i]), dat29(ord29[i]));
    set_req(0, 1'b1, 4'd1, dat29(1), 4'd0);
    set_req(1, 1'b1, 4'd2, dat29(2), 4'd0);
    set_req(2, 1'b1, 4'd4, dat29(4), 4'd0);
    repeat (6) tick();
    idle();
    drain("rr_drain");

    // LSU back-to-back into a full queue; third request must be dropped
    do_reset();
`ifdef CDB_FIXED_PRIORITY_EN
    push(4'd1, 32'h3000_00A1); push(4'd2, 32'h3000_00A2); push(4'd3, 32'h3000_00A3);
    push(4'd5, 32'h3000_00B1); push(4'd6, 32'h3000_00B2);
`else
    push(4'd1, 32'h3000_00A1); push(4'd5, 32'h3000_00B1); push(4'd2, 32'h3000_00A2);
    push(4'd6, 32'h3000_00B2); push(4'd3, 32'h3000_00A3);
`endif
    check("full1_empty", full1, 0);
    set_req(0, 1'b1, 4'd1, 32'h3000_00A1, 4'd0);
    set_req(1, 1'b1, 4'd5, 32'h3000_00B1, 4'd0);
    tick();
    check("full1_after1", full1, 0);
    set_req(0, 1'b1, 4'd2, 32'h3000_00A2, 4'd0);
    set_req(1, 1'b1, 4'd6, 32'h3000_00B2, 4'd0);
    tick();
    check("full1_after2", full1, 1);
    set_req(0, 1'b1, 4'd3, 32'h3000_00A3, 4'd0);
    set_req(1, 1'b1, 4'd7, 32'h3000_00B3, 4'd0);
    tick();
`ifdef CDB_FIXED_PRIORITY_EN
    check("full1_held", full1, 1);
`else
    check("full1_popped", full1, 0);
`endif
    idle();
    drain("full_drain");

    // Mispredict on branch 1 (free also raised): only bit-1-clear entries survive
    do_reset();
    push(4'd6, 32'h4000_0006);
    push(4'd8, 32'h4000_0008);
    set_req(0, 1'b1, 4'd5, 32'h4000_0005, 4'b0010);
    set_req(1, 1'b1, 4'd6, 32'h4000_0006, 4'b0001);
    tick();
    set_req(0, 1'b1, 4'd8, 32'h4000_0008, 4'b0001);
    set_req(1, 1'b0, 4'd0, 32'd0, 4'd0);
    set_req(2, 1'b1, 4'd7, 32'h4000_0007, 4'b0110);
    misTaken = 1'b1;
    bFreeEn = 1'b1;
    bFreeNum = 2'd1;
    tick();
    idle();
    drain("squash_drain");

    // Branch 0 freed before its mispredict broadcast: entries survive
    do_reset();
    push(4'd9, 32'h5000_0009);
    push(4'd10, 32'h5000_000A);
    push(4'd11, 32'h5000_000B);
    set_req(0, 1'b1, 4'd9, 32'h5000_0009, 4'b0000);
    set_req(1, 1'b1, 4'd10, 32'h5000_000A, 4'b0001);
    tick();
    idle();
    bFreeEn = 1'b1;
    bFreeNum = 2'd0;
    set_req(2, 1'b1, 4'd11, 32'h5000_000B, 4'b0001);
    tick();
    idle();
    misTaken = 1'b1;
    bFreeNum = 2'd0;
    tick();
    idle();
    drain("free_drain");

    // rdy low for three edges with loaded queues: everything frozen, then same order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      case (ord33[i])
        0: push(4'd1, 32'h6000_00D1);
        1: push(4'd2, 32'h6000_00D2);
        2: push(4'd4, 32'h6000_00D4);
        3: push(4'd1, 32'h6000_00E1);
        4: push(4'd2, 32'h6000_00E2);
        default: push(4'd4, 32'h6000_00E4);
      endcase
    end
    set_req(0, 1'b1, 4'd1, 32'h6000_00D1, 4'b0001);
    set_req(1, 1'b1, 4'd2, 32'h6000_00D2, 4'b0001);
    set_req(2, 1'b1, 4'd4, 32'h6000_00D4, 4'b0001);
    tick();
    set_req(0, 1'b1, 4'd1, 32'h6000_00E1, 4'b0001);
    set_req(1, 1'b1, 4'd2, 32'h6000_00E2, 4'b0001);
    set_req(2, 1'b1, 4'd4, 32'h6000_00E4, 4'b0001);
    tick();
    rdy = 1'b0;
    misTaken = 1'b1;
    bFreeNum = 2'd0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 4'd15, 32'hBAD0_0000, 4'b0001);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_frozen", {enWrtO, WrtTagO, WrtDataO, full0, full1, full2},
            {1'b1, 4'd1, 32'h6000_00D1, 3'b011});
    end
    idle();
    drain("stall_drain");

    // Reset mid-traffic discards queued work
    do_reset();
    set_req(0, 1'b1, 4'd12, 32'h7000_000C, 4'd0);
    set_req(1, 1'b1, 4'd13, 32'h7000_000D, 4'd0);
    set_req(2, 1'b1, 4'd14, 32'h7000_000E, 4'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("midrst_out", {enWrtO, WrtTagO, WrtDataO}, {1'b0, 4'b1000, 32'd0});
    check("midrst_full", {full0, full1, full2}, 3'b000);
    repeat (8) tick();
    check("midrst_enWrtO", enWrtO, 0);

    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
